// File: rtl/conv_window_buffer.sv
// conv_window_buffer
//   Streaming line buffer and window generator feeding the convolution
//   datapath. Accepts one raster-order pixel per cycle, keeps KERN_DIM-1
//   previous rows, and emits each complete KERN_DIM x KERN_DIM neighbourhood
//   as a flattened window one cycle after its bottom-right pixel arrives.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears counters and outputs
//   in_valid      in_pixel is accepted this cycle
//   in_pixel      signed pixel, raster order
//   in_sof        with in_valid: this pixel is (row 0, col 0)
//   window_valid  one-cycle strobe, window holds a new neighbourhood
//   window        element i*KERN_DIM+j at [(i*KERN_DIM+j)*DATA_WIDTH +: DATA_WIDTH],
//                 element 0 is the top-left (oldest) pixel
//   win_row       row of the newest pixel in window
//   win_col       column of the newest pixel in window
//   frame_done    one-cycle strobe after the last pixel of a frame
module conv_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int KERN_DIM   = 5,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  input  logic [DATA_WIDTH-1:0]                   in_pixel,
  input  logic                                    in_sof,
  output logic                                    window_valid,
  output logic [KERN_DIM*KERN_DIM*DATA_WIDTH-1:0] window,
  output logic [$clog2(IMG_HEIGHT)-1:0]           win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]            win_col,
  output logic                                    frame_done
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int WW = KERN_DIM * KERN_DIM * DATA_WIDTH;

  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic                  r_win_valid;
  logic [WW-1:0]         r_window;
  logic [RW-1:0]         r_win_row;
  logic [CW-1:0]         r_win_col;
  logic                  r_frame_done;

  // r_lb[k][c] holds the pixel of column c from k+1 rows above the current row.
  logic [DATA_WIDTH-1:0] r_lb   [KERN_DIM-1][IMG_WIDTH];
  // r_cols[j] is the full vertical column vector of the j-th oldest of the
  // last KERN_DIM-1 accepted pixels; index [j][i], i = 0 is the top row.
  logic [DATA_WIDTH-1:0] r_cols [KERN_DIM-1][KERN_DIM];

  logic [RW-1:0]         w_row;
  logic [CW-1:0]         w_col;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_qualify;
  logic [DATA_WIDTH-1:0] w_col_vec [KERN_DIM];
  logic [WW-1:0]         w_window;

  // Position of the pixel being accepted; in_sof forces it to (0,0).
  always_comb begin
    w_row = in_sof ? '0 : r_row;
    w_col = in_sof ? '0 : r_col;
  end

  assign w_last_col = (w_col == CW'(IMG_WIDTH - 1));
  assign w_last_row = (w_row == RW'(IMG_HEIGHT - 1));
  // Requiring the row to be >= KERN_DIM-1 of the current frame guarantees
  // the line buffer never contributes rows from a previous or aborted frame.
  assign w_qualify  = (w_row >= RW'(KERN_DIM - 1)) && (w_col >= CW'(KERN_DIM - 1));

  // Vertical slice ending at the incoming pixel, top row first.
  always_comb begin
    for (int i = 0; i < KERN_DIM; i++) w_col_vec[i] = in_pixel;
    for (int i = 0; i < KERN_DIM - 1; i++) w_col_vec[i] = r_lb[KERN_DIM-2-i][w_col];
  end

  always_comb begin
    w_window = '0;
    for (int i = 0; i < KERN_DIM; i++) begin
      for (int j = 0; j < KERN_DIM - 1; j++)
        w_window[(i*KERN_DIM+j)*DATA_WIDTH +: DATA_WIDTH] = r_cols[j][i];
      w_window[(i*KERN_DIM+KERN_DIM-1)*DATA_WIDTH +: DATA_WIDTH] = w_col_vec[i];
    end
  end

  // Pixel storage needs no reset: only rows written in the current frame
  // can ever reach a qualifying window.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb[0][w_col] <= in_pixel;
      for (int k = 1; k < KERN_DIM - 1; k++) r_lb[k][w_col] <= r_lb[k-1][w_col];
      for (int j = 0; j < KERN_DIM - 2; j++)
        for (int i = 0; i < KERN_DIM; i++) r_cols[j][i] <= r_cols[j+1][i];
      for (int i = 0; i < KERN_DIM; i++) r_cols[KERN_DIM-2][i] <= w_col_vec[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row        <= '0;
      r_col        <= '0;
      r_win_valid  <= 1'b0;
      r_window     <= '0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (in_valid) begin
        if (w_qualify) begin
          r_win_valid <= 1'b1;
          r_window    <= w_window;
          r_win_row   <= w_row;
          r_win_col   <= w_col;
        end
        r_frame_done <= w_last_row && w_last_col;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  assign window_valid = r_win_valid;
  assign window       = r_window;
  assign win_row      = r_win_row;
  assign win_col      = r_win_col;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_conv_window_buffer.sv
module tb_conv_window_buffer;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int WW = K * K * DW;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic          window_valid;
  logic          frame_done;
  logic [WW-1:0] window;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  conv_window_buffer #(
    .DATA_WIDTH(DW), .KERN_DIM(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_sof(in_sof), .window_valid(window_valid), .window(window),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: the frame as a 2-D image plus the expected outputs.
  logic [DW-1:0] img [H][W];
  int            mr = 0, mc = 0, m_strobes = 0;
  logic          exp_valid = 1'b0, exp_fd = 1'b0;
  logic [WW-1:0] exp_win = '0;
  int            exp_row = 0, exp_col = 0;

  typedef struct {
    logic [WW-1:0] w;
    int            r;
    int            c;
  } strobe_t;
  strobe_t log_q[$];
  strobe_t ref_q[$];
  strobe_t cs;
  strobe_t s;
  int      fd_count = 0;
  bit      chk_en = 1'b0;
  logic [WW-1:0] ones = '1;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int i);
    return w[i*DW +: DW];
  endfunction

  task automatic model(input logic v, input logic [DW-1:0] p, input logic sf);
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (v) begin
      if (sf) begin mr = 0; mc = 0; end
      img[mr][mc] = p;
      if (mr >= K-1 && mc >= K-1) begin
        exp_valid = 1'b1;
        m_strobes++;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            exp_win[(i*K+j)*DW +: DW] = img[mr-(K-1)+i][mc-(K-1)+j];
        exp_row = mr;
        exp_col = mc;
      end
      exp_fd = (mr == H-1 && mc == W-1);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_fd = 1'b0; exp_win = '0;
    exp_row = 0; exp_col = 0; mr = 0; mc = 0;
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("window_valid", {{(WW-1){1'b0}}, window_valid}, {{(WW-1){1'b0}}, exp_valid});
      check("frame_done", {{(WW-1){1'b0}}, frame_done}, {{(WW-1){1'b0}}, exp_fd});
      check("window", window, exp_win);
      check("win_row", WW'(win_row), WW'(exp_row));
      check("win_col", WW'(win_col), WW'(exp_col));
      if (window_valid === 1'b1) begin
        cs.w = window; cs.r = int'(win_row); cs.c = int'(win_col);
        log_q.push_back(cs);
      end
      if (frame_done === 1'b1) fd_count++;
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] p, input logic sf);
    @(negedge clk);
    in_valid = v; in_pixel = p; in_sof = sf;
    @(posedge clk);
    model(v, p, sf);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, DW'($urandom), 1'b0);
  endtask

  task automatic send_pixel(input int r, input int c, input int base, input bit gaps, input bit allneg);
    logic [DW-1:0] p;
    p = allneg ? 16'hFFFF : DW'(base + r*W + c);
    // Random gaps, with stray in_sof while in_valid is low (must be ignored).
    if (gaps && $urandom_range(0, 1) == 1)
      repeat ($urandom_range(1, 3)) step(1'b0, DW'($urandom), 1'($urandom_range(0, 1)));
    step(1'b1, p, (r == 0 && c == 0));
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit allneg);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pixel(r, c, base, gaps, allneg);
  endtask

  task automatic clear_log();
    log_q.delete();
    fd_count = 0;
    m_strobes = 0;
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;

    // Gapless frame, pixel = r*8+c.
    clear_log();
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check("g_model_cnt", WW'(m_strobes), WW'(16));
    check("g_cnt", WW'(log_q.size()), WW'(16));
    check("g_fd_cnt", WW'(fd_count), WW'(1));
    s = log_q[0];
    check("g_first_e0", WW'(elem(s.w, 0)), WW'(0));
    check("g_first_e4", WW'(elem(s.w, 4)), WW'(4));
    check("g_first_e5", WW'(elem(s.w, 5)), WW'(8));
    check("g_first_e24", WW'(elem(s.w, 24)), WW'(36));
    check("g_first_row", WW'(s.r), WW'(4));
    check("g_first_col", WW'(s.c), WW'(4));
    s = log_q[15];
    check("g_last_e24", WW'(elem(s.w, 24)), WW'(63));
    // Row boundary: (4,7) then directly (5,4).
    s = log_q[3];
    check("rb_a_row", WW'(s.r), WW'(4));
    check("rb_a_col", WW'(s.c), WW'(7));
    s = log_q[4];
    check("rb_b_row", WW'(s.r), WW'(5));
    check("rb_b_col", WW'(s.c), WW'(4));
    check("rb_b_e0", WW'(elem(s.w, 0)), WW'(8));
    ref_q = log_q;

    // Same frame with random gaps: identical windows, in order.
    clear_log();
    send_frame(0, 1'b1, 1'b0);
    idle(3);
    check("gap_cnt", WW'(log_q.size()), WW'(16));
    check("gap_fd_cnt", WW'(fd_count), WW'(1));
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      s = log_q[i];
      check("gap_win", s.w, ref_q[i].w);
      check("gap_pos", WW'(s.r * 16 + s.c), WW'(ref_q[i].r * 16 + ref_q[i].c));
    end

    // Back-to-back frames, second offset by 100.
    clear_log();
    send_frame(0, 1'b0, 1'b0);
    send_frame(100, 1'b0, 1'b0);
    idle(3);
    check("b2b_cnt", WW'(log_q.size()), WW'(32));
    check("b2b_fd_cnt", WW'(fd_count), WW'(2));
    s = log_q[16];
    check("b2b_row", WW'(s.r), WW'(4));
    check("b2b_col", WW'(s.c), WW'(4));
    check("b2b_e0", WW'(elem(s.w, 0)), WW'(100));
    check("b2b_e24", WW'(elem(s.w, 24)), WW'(136));

    // All pixels -1.
    clear_log();
    send_frame(0, 1'b0, 1'b1);
    idle(3);
    check("neg_cnt", WW'(log_q.size()), WW'(16));
    for (int i = 0; i < log_q.size(); i++) begin
      s = log_q[i];
      check("neg_win", s.w, ones);
    end

    // Reset at pixel (5,2), then restart with in_sof.
    clear_log();
    for (int idx = 0; idx <= 5*W + 2; idx++) send_pixel(idx / W, idx % W, 0, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    check("rst_pre_cnt", WW'(log_q.size()), WW'(4));
    check("rst_pre_fd", WW'(fd_count), WW'(0));
    clear_log();
    send_frame(50, 1'b0, 1'b0);
    idle(3);
    check("rst_cnt", WW'(log_q.size()), WW'(16));
    check("rst_fd", WW'(fd_count), WW'(1));
    s = log_q[0];
    check("rst_row", WW'(s.r), WW'(4));
    check("rst_col", WW'(s.c), WW'(4));
    check("rst_e0", WW'(elem(s.w, 0)), WW'(50));
    check("rst_e24", WW'(elem(s.w, 24)), WW'(86));

    // Random pixels, random valid, occasional in_sof (valid or not).
    clear_log();
    for (int n = 0; n < 800; n++)
      step(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 149) == 0));
    idle(3);
    check("rand_cnt", WW'(log_q.size()), WW'(m_strobes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
